// File: rtl/racket_control.sv
// rtl/racket_control.sv - button sync/debounce, per-player racket FSMs with acceleration and clamping, serve pulse.
// Build option: define RACKET_DEBOUNCE_EN to insert the per-button debouncers after the synchronisers.
module racket_control #(
  parameter int Y_MIN           = 51,
  parameter int Y_MAX           = 637,
  parameter int Y_RESET         = 344,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_MAX       = 8,
  parameter int ACCEL_FRAMES    = 4,
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic       clk65MHz,
  input  logic       rst_n,
  input  logic       end_of_frame,
  input  logic       btn_p1_up,
  input  logic       btn_p1_down,
  input  logic       btn_p2_up,
  input  logic       btn_p2_down,
  input  logic       btn_serve,
  input  logic       screen_idle,
  input  logic       screen_multi,
  output logic [9:0] pos_of_player_1,
  output logic [9:0] pos_of_player_2,
  output logic       serve
);

  localparam int NBTN  = 5;
  localparam int SPD_W = $clog2(SPEED_MAX + 1);
  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  typedef enum logic [1:0] {HOLD, UP, DOWN} dir_t;

  // Bit order: {serve, p2_down, p2_up, p1_down, p1_up}
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] btn_db;

  assign btn_raw = {btn_serve, btn_p2_down, btn_p2_up, btn_p1_down, btn_p1_up};

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef RACKET_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt [NBTN];

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign btn_db = sync2;
`endif

  // Serve edge seen during the menu is dropped, not held over.
  logic serve_prev;

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      serve_prev <= 1'b0;
      serve      <= 1'b0;
    end else begin
      serve_prev <= btn_db[4];
      serve      <= btn_db[4] & ~serve_prev & ~screen_idle;
    end
  end

  function automatic dir_t decode(input logic up, input logic down);
    case ({up, down})
      2'b10:   return UP;
      2'b01:   return DOWN;
      default: return HOLD;
    endcase
  endfunction

  function automatic logic [9:0] move(input logic [9:0] pos, input dir_t dir,
                                      input logic [SPD_W-1:0] step);
    logic [10:0] p11;
    logic [10:0] s11;
    p11 = {1'b0, pos};
    s11 = 11'(step);
    if (dir == UP)
      return (p11 < 11'(Y_MIN) + s11) ? 10'(Y_MIN) : 10'(p11 - s11);
    else if (dir == DOWN)
      return (p11 + s11 > 11'(Y_MAX)) ? 10'(Y_MAX) : 10'(p11 + s11);
    return pos;
  endfunction

  dir_t             dir_req [2];
  dir_t             state_q [2];
  dir_t             state_d [2];
  logic [SPD_W-1:0] speed_q [2];
  logic [SPD_W-1:0] speed_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [9:0]       pos_q   [2];
  logic [9:0]       pos_d   [2];

  always_comb begin
    dir_req[0] = decode(btn_db[0], btn_db[1]);
    dir_req[1] = screen_multi ? decode(btn_db[2], btn_db[3]) : HOLD;
  end

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= HOLD;
        speed_q[p] <= SPD_W'(SPEED_MIN);
        cnt_q[p]   <= '0;
        pos_q[p]   <= 10'(Y_RESET);
      end
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  // A start or reversal behaves as a held frame from (SPEED_MIN, cnt 0), so
  // the first frame of a move already counts toward acceleration.
  always_comb begin
    logic [SPD_W-1:0] base_speed;
    logic [CNT_W-1:0] base_cnt;
    base_speed = '0;
    base_cnt   = '0;
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      speed_d[p] = speed_q[p];
      cnt_d[p]   = cnt_q[p];
      pos_d[p]   = pos_q[p];
      base_speed = speed_q[p];
      base_cnt   = cnt_q[p];
      if (end_of_frame) begin
        if (dir_req[p] == HOLD) begin
          state_d[p] = HOLD;
          speed_d[p] = SPD_W'(SPEED_MIN);
          cnt_d[p]   = '0;
        end else begin
          if (dir_req[p] != state_q[p]) begin
            base_speed = SPD_W'(SPEED_MIN);
            base_cnt   = '0;
          end
          state_d[p] = dir_req[p];
          pos_d[p]   = move(pos_q[p], dir_req[p], base_speed);
          if (base_cnt == CNT_W'(ACCEL_FRAMES - 1)) begin
            cnt_d[p]   = '0;
            speed_d[p] = (base_speed >= SPD_W'(SPEED_MAX)) ? SPD_W'(SPEED_MAX)
                                                           : base_speed + 1'b1;
          end else begin
            cnt_d[p]   = base_cnt + 1'b1;
            speed_d[p] = base_speed;
          end
        end
      end
      if (screen_idle || (p == 1 && !screen_multi)) begin
        state_d[p] = HOLD;
        speed_d[p] = SPD_W'(SPEED_MIN);
        cnt_d[p]   = '0;
        pos_d[p]   = 10'(Y_RESET);
      end
    end
  end

  assign pos_of_player_1 = pos_q[0];
  assign pos_of_player_2 = pos_q[1];

endmodule

// File: tb/tb_racket_control.sv
// tb/tb_racket_control.sv - directed self-checking bench for racket_control (either RACKET_DEBOUNCE_EN build).
module tb_racket_control;

  logic       clk65MHz = 1'b0;
  logic       rst_n = 1'b1;
  logic       end_of_frame = 1'b0;
  logic       btn_p1_up = 1'b0;
  logic       btn_p1_down = 1'b0;
  logic       btn_p2_up = 1'b0;
  logic       btn_p2_down = 1'b0;
  logic       btn_serve = 1'b0;
  logic       screen_idle = 1'b0;
  logic       screen_multi = 1'b1;
  logic [9:0] pos_of_player_1;
  logic [9:0] pos_of_player_2;
  logic       serve;

  int total = 0;
  int bad   = 0;

  localparam int DEB = 4;
`ifdef RACKET_DEBOUNCE_EN
  localparam int SERVE_LAT = DEB + 3;
`else
  localparam int SERVE_LAT = 3;
`endif

  racket_control #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk65MHz        (clk65MHz),
    .rst_n           (rst_n),
    .end_of_frame    (end_of_frame),
    .btn_p1_up       (btn_p1_up),
    .btn_p1_down     (btn_p1_down),
    .btn_p2_up       (btn_p2_up),
    .btn_p2_down     (btn_p2_down),
    .btn_serve       (btn_serve),
    .screen_idle     (screen_idle),
    .screen_multi    (screen_multi),
    .pos_of_player_1 (pos_of_player_1),
    .pos_of_player_2 (pos_of_player_2),
    .serve           (serve)
  );

  always #5 clk65MHz = ~clk65MHz;

  task automatic tick(input int n);
    repeat (n) @(negedge clk65MHz);
  endtask

  task automatic settle();
    tick(12);
  endtask

  task automatic frame();
    tick(3);
    end_of_frame = 1'b1;
    @(negedge clk65MHz);
    end_of_frame = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pos_of_player_1 !== 10'd344) begin
      bad++; $display("FAIL reset_p1: got %0d want 344", pos_of_player_1);
    end
    total++;
    if (pos_of_player_2 !== 10'd344) begin
      bad++; $display("FAIL reset_p2: got %0d want 344", pos_of_player_2);
    end
    total++;
    if (serve !== 1'b0) begin
      bad++; $display("FAIL reset_serve: got %b want 0", serve);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_accel();
    int exp_pos [10] = '{346, 348, 350, 352, 355, 358, 361, 364, 368, 372};
    btn_p1_down = 1'b1;
    settle();
    for (int i = 0; i < 10; i++) begin
      frame();
      total++;
      if (pos_of_player_1 !== 10'(exp_pos[i])) begin
        bad++; $display("FAIL accel_f%0d: got %0d want %0d", i + 1, pos_of_player_1, exp_pos[i]);
      end
    end
    total++;
    if (pos_of_player_2 !== 10'd344) begin
      bad++; $display("FAIL accel_p2_still: got %0d want 344", pos_of_player_2);
    end
    btn_p1_down = 1'b0;
    settle();
  endtask

  task automatic test_reversal();
    int exp_down [5] = '{346, 348, 350, 352, 355};
    btn_p2_down = 1'b1;
    settle();
    for (int i = 0; i < 5; i++) begin
      frame();
      total++;
      if (pos_of_player_2 !== 10'(exp_down[i])) begin
        bad++; $display("FAIL rev_down_f%0d: got %0d want %0d", i + 1, pos_of_player_2, exp_down[i]);
      end
    end
    btn_p2_down = 1'b0;
    btn_p2_up   = 1'b1;
    settle();
    frame();
    total++;
    if (pos_of_player_2 !== 10'd353) begin
      bad++; $display("FAIL rev_first_up: got %0d want 353", pos_of_player_2);
    end
    frame();
    total++;
    if (pos_of_player_2 !== 10'd351) begin
      bad++; $display("FAIL rev_second_up: got %0d want 351", pos_of_player_2);
    end
    btn_p2_down = 1'b1;
    settle();
    frame();
    frame();
    total++;
    if (pos_of_player_2 !== 10'd351) begin
      bad++; $display("FAIL both_frozen: got %0d want 351", pos_of_player_2);
    end
    btn_p2_up = 1'b0;
    settle();
    frame();
    total++;
    if (pos_of_player_2 !== 10'd353) begin
      bad++; $display("FAIL speed_reset_after_both: got %0d want 353", pos_of_player_2);
    end
    btn_p2_down = 1'b0;
    settle();
  endtask

  task automatic test_mode();
    screen_multi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_p2_up   = i[0];
      btn_p2_down = ~i[0];
      settle();
      frame();
      total++;
      if (pos_of_player_2 !== 10'd344) begin
        bad++; $display("FAIL single_p2_held_%0d: got %0d want 344", i, pos_of_player_2);
      end
    end
    btn_p2_up   = 1'b0;
    btn_p2_down = 1'b1;
    screen_multi = 1'b1;
    settle();
    frame();
    total++;
    if (pos_of_player_2 !== 10'd346) begin
      bad++; $display("FAIL multi_resume: got %0d want 346", pos_of_player_2);
    end
    screen_idle = 1'b1;
    @(negedge clk65MHz);
    screen_idle = 1'b0;
    total++;
    if (pos_of_player_1 !== 10'd344 || pos_of_player_2 !== 10'd344) begin
      bad++; $display("FAIL idle_recentre: got %0d/%0d want 344/344", pos_of_player_1, pos_of_player_2);
    end
    btn_p2_down = 1'b0;
    settle();
  endtask

  task automatic test_clamp();
    btn_p1_up = 1'b1;
    settle();
    for (int i = 1; i <= 49; i++) begin
      frame();
      if (i == 46) begin
        total++;
        if (pos_of_player_1 !== 10'd60) begin
          bad++; $display("FAIL clamp_f46: got %0d want 60", pos_of_player_1);
        end
      end else if (i == 47) begin
        total++;
        if (pos_of_player_1 !== 10'd52) begin
          bad++; $display("FAIL clamp_f47: got %0d want 52", pos_of_player_1);
        end
      end else if (i >= 48) begin
        total++;
        if (pos_of_player_1 !== 10'd51) begin
          bad++; $display("FAIL clamp_f%0d: got %0d want 51", i, pos_of_player_1);
        end
      end
    end
    btn_p1_up = 1'b0;
    settle();
  endtask

  task automatic test_serve();
    int first = 0;
    int ones  = 0;
`ifdef RACKET_DEBOUNCE_EN
    for (int g = 0; g < 2; g++) begin
      btn_serve = 1'b1;
      tick(2);
      btn_serve = 1'b0;
      tick(4);
    end
`endif
    btn_serve = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk65MHz);
      if (serve === 1'b1) begin
        ones++;
        if (first == 0) first = k;
      end
    end
    total++;
    if (ones !== 1) begin
      bad++; $display("FAIL serve_count: got %0d want 1", ones);
    end
    total++;
    if (first !== SERVE_LAT) begin
      bad++; $display("FAIL serve_latency: got %0d want %0d", first, SERVE_LAT);
    end
    btn_serve = 1'b0;
    settle();
  endtask

  task automatic test_serve_idle();
    int ones = 0;
    screen_idle = 1'b1;
    btn_serve   = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk65MHz);
      if (serve === 1'b1) ones++;
    end
    screen_idle = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk65MHz);
      if (serve === 1'b1) ones++;
    end
    total++;
    if (ones !== 0) begin
      bad++; $display("FAIL serve_idle: got %0d pulses want 0", ones);
    end
    btn_serve = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid();
    btn_p1_down = 1'b1;
    btn_p2_up   = 1'b1;
    settle();
    frame();
    frame();
    total++;
    if (pos_of_player_1 !== 10'd348 || pos_of_player_2 !== 10'd340) begin
      bad++; $display("FAIL premove: got %0d/%0d want 348/340", pos_of_player_1, pos_of_player_2);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (pos_of_player_1 !== 10'd344 || pos_of_player_2 !== 10'd344 || serve !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got %0d/%0d/%b want 344/344/0",
                      pos_of_player_1, pos_of_player_2, serve);
    end
    btn_p1_down = 1'b0;
    btn_p2_up   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_accel();
    test_reversal();
    test_mode();
    test_clamp();
    test_serve();
    test_serve_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
